// File: rtl/scene_init_pkg.sv
// Shared types and the pixel-word pack helper for the scene initialiser.
// Used by rect_walker (perimeter or SCENE_INIT_FILL_EN raster) and scene_init_engine.
package scene_init_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAW, ST_DONE} state_e;
  typedef enum logic       {PH_BORDER, PH_SPRITES} phase_e;
  typedef enum logic [1:0] {E_TOP, E_RIGHT, E_BOTTOM, E_LEFT} edge_e;

  localparam int DEF_WORD_W  = 8 + 7 + 3;
  localparam int MAX_FIELD_W = 32;
  localparam int MAX_WORD_W  = 3 * MAX_FIELD_W;

  // Fields arrive zero-extended; the caller truncates the result to its word width.
  function automatic logic [MAX_WORD_W-1:0] pack_word(
    input logic [MAX_FIELD_W-1:0] x,
    input logic [MAX_FIELD_W-1:0] y,
    input logic [MAX_FIELD_W-1:0] c,
    input int unsigned            y_w,
    input int unsigned            c_w
  );
    return ({64'b0, x} << (y_w + c_w)) | ({64'b0, y} << c_w) | {64'b0, c};
  endfunction

endpackage

// File: rtl/scene_init_engine_rect_walker.sv
// Rectangle point sequencer: clockwise perimeter by default, raster fill of the
// whole rectangle when SCENE_INIT_FILL_EN is defined.
module rect_walker
  import scene_init_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int BOX_X0 = 40,
  parameter int BOX_Y0 = 40,
  parameter int BOX_W  = 80,
  parameter int BOX_H  = 40
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           step,
  input  logic           restart,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_FIRST = X_W'(BOX_X0);
  localparam logic [X_W-1:0] X_LAST  = X_W'(BOX_X0 + BOX_W - 1);
  localparam logic [Y_W-1:0] Y_FIRST = Y_W'(BOX_Y0);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(BOX_Y0 + BOX_H - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  assign x = x_q;
  assign y = y_q;

`ifdef SCENE_INIT_FILL_EN
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (restart) begin
      x_d = X_FIRST;
      y_d = Y_FIRST;
    end else if (step) begin
      if (x_q == X_LAST) begin
        x_d = X_FIRST;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  assign last = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= X_FIRST;
      y_q <= Y_FIRST;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
`else
  localparam logic [X_W-1:0] X_PEN    = X_W'(BOX_X0 + BOX_W - 2);
  localparam logic [Y_W-1:0] Y_SECOND = Y_W'(BOX_Y0 + 1);
  localparam logic [Y_W-1:0] Y_PEN    = Y_W'(BOX_Y0 + BOX_H - 2);
  // With a 2-pixel-high box the left edge is empty and the walk ends on the bottom edge.
  localparam logic           SHORT_H  = (BOX_H == 2);

  edge_e edge_q, edge_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    edge_d = edge_q;
    if (restart) begin
      x_d    = X_FIRST;
      y_d    = Y_FIRST;
      edge_d = E_TOP;
    end else if (step) begin
      case (edge_q)
        E_TOP:
          if (x_q == X_LAST) begin
            edge_d = E_RIGHT;
            y_d    = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        E_RIGHT:
          if (y_q == Y_LAST) begin
            edge_d = E_BOTTOM;
            x_d    = X_PEN;
          end else begin
            y_d = y_q + Y_W'(1);
          end
        E_BOTTOM:
          if (x_q == X_FIRST) begin
            edge_d = E_LEFT;
            y_d    = Y_PEN;
          end else begin
            x_d = x_q - X_W'(1);
          end
        E_LEFT:  y_d = y_q - Y_W'(1);
        default: ;
      endcase
    end
  end

  assign last = ((edge_q == E_LEFT) && (y_q == Y_SECOND)) ||
                (SHORT_H && (edge_q == E_BOTTOM) && (x_q == X_FIRST));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q    <= X_FIRST;
      y_q    <= Y_FIRST;
      edge_q <= E_TOP;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      edge_q <= edge_d;
    end
  end
`endif

endmodule

// File: rtl/scene_init_engine.sv
// Scene initialiser: border (or SCENE_INIT_FILL_EN raster fill) then sprite table,
// one LOAD/DRAW handshake per pixel word, draw flow-controlled by draw_ready.
module scene_init_engine
  import scene_init_pkg::*;
#(
  parameter int             X_W       = 8,
  parameter int             Y_W       = 7,
  parameter int             C_W       = 3,
  parameter int             BOX_X0    = 40,
  parameter int             BOX_Y0    = 40,
  parameter int             BOX_W     = 80,
  parameter int             BOX_H     = 40,
  parameter logic [C_W-1:0] BOX_C     = 3'b111,
  parameter int             N_SPRITES = 3,
  parameter logic [N_SPRITES*(X_W+Y_W+C_W)-1:0] SPRITE_TABLE =
    {8'd100, 7'd79, 3'd4, 8'd60, 7'd79, 3'd4, 8'd80, 7'd79, 3'd1}
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic                   draw_ready,
  output logic [X_W+Y_W+C_W-1:0] init_out,
  output logic                   load_init,
  output logic                   draw,
  output logic                   busy,
  output logic                   i_done
);

  localparam int WORD_W = X_W + Y_W + C_W;
  localparam int SPR_W  = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int SPR_N  = 1 << SPR_W;
  localparam logic [SPR_W-1:0] SPR_LAST = SPR_W'(N_SPRITES - 1);

  if (BOX_W < 2 || BOX_H < 2) begin : g_bad_size
    $error("scene_init_engine: BOX_W and BOX_H must be at least 2");
  end
  if (BOX_X0 + BOX_W - 1 >= (1 << X_W) || BOX_Y0 + BOX_H - 1 >= (1 << Y_W)) begin : g_bad_fit
    $error("scene_init_engine: border does not fit the coordinate widths");
  end
  if (N_SPRITES < 1 || X_W > MAX_FIELD_W || Y_W > MAX_FIELD_W || C_W > MAX_FIELD_W) begin : g_bad_cfg
    $error("scene_init_engine: unsupported sprite count or field width");
  end

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [SPR_W-1:0]   spr_idx_q, spr_idx_d;
  logic [WORD_W-1:0]  init_q, init_d;
  logic               last_q, last_d;
  logic [WORD_W-1:0]  spr_tab [SPR_N];
  logic [WORD_W-1:0]  cur_word;
  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  logic               w_last, w_step, w_restart, enter_load, finish;

  for (genvar i = 0; i < SPR_N; i++) begin : g_tab
    if (i < N_SPRITES) begin : g_used
      assign spr_tab[i] = SPRITE_TABLE[i*WORD_W +: WORD_W];
    end else begin : g_pad
      assign spr_tab[i] = '0;
    end
  end

  rect_walker #(
    .X_W(X_W), .Y_W(Y_W), .BOX_X0(BOX_X0), .BOX_Y0(BOX_Y0), .BOX_W(BOX_W), .BOX_H(BOX_H)
  ) u_walker (
    .clock(clock), .reset(reset), .step(w_step), .restart(w_restart),
    .x(w_x), .y(w_y), .last(w_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_DRAW;
      ST_DRAW: if (draw_ready) state_d = last_q ? ST_DONE : ST_LOAD;
      ST_DONE: if (go) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_init = (state_q == ST_LOAD);
    draw      = (state_q == ST_DRAW);
    busy      = (state_q == ST_LOAD) || (state_q == ST_DRAW);
    i_done    = (state_q == ST_DONE);
  end

  assign enter_load = (state_d == ST_LOAD);
  assign finish     = (state_q == ST_DRAW) && (state_d == ST_DONE);

  always_comb begin
    if (phase_q == PH_BORDER)
      cur_word = WORD_W'(pack_word(MAX_FIELD_W'(w_x), MAX_FIELD_W'(w_y), MAX_FIELD_W'(BOX_C), Y_W, C_W));
    else
      cur_word = spr_tab[spr_idx_q];
  end

  // The point pointer runs one word ahead: it advances as the current word is latched.
  always_comb begin
    init_d    = init_q;
    last_d    = last_q;
    phase_d   = phase_q;
    spr_idx_d = spr_idx_q;
    w_step    = 1'b0;
    w_restart = 1'b0;
    if (enter_load) begin
      init_d = cur_word;
      last_d = (phase_q == PH_SPRITES) && (spr_idx_q == SPR_LAST);
      if (phase_q == PH_BORDER) begin
        if (w_last) begin
          phase_d   = PH_SPRITES;
          spr_idx_d = '0;
          w_restart = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end else if (spr_idx_q != SPR_LAST) begin
        spr_idx_d = spr_idx_q + SPR_W'(1);
      end
    end
    if (finish) begin
      phase_d   = PH_BORDER;
      spr_idx_d = '0;
      w_restart = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_q    <= '0;
      last_q    <= 1'b0;
      phase_q   <= PH_BORDER;
      spr_idx_q <= '0;
    end else begin
      init_q    <= init_d;
      last_q    <= last_d;
      phase_q   <= phase_d;
      spr_idx_q <= spr_idx_d;
    end
  end

  assign init_out = init_q;

endmodule

// File: tb/tb_scene_init_engine.sv
// Self-checking bench for scene_init_engine: default-parameter instance plus a 2x2 box.
// Reference list follows SCENE_INIT_FILL_EN the same way the design does.
module tb_scene_init_engine;

  logic clk = 1'b0;
  logic reset, go0, go1, draw_ready;
  logic [17:0] init0, init1;
  logic li0, dr0, bz0, dn0, li1, dr1, bz1, dn1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] exp_q[$];
  logic [17:0] got[$];
  logic        hold_draw[$];
  logic [17:0] hold_word[$];
  int          t_first, t_done;
  bit          timed_out;

  always #5 clk = ~clk;

  scene_init_engine u_dut0 (
    .clock(clk), .reset(reset), .go(go0), .draw_ready(draw_ready),
    .init_out(init0), .load_init(li0), .draw(dr0), .busy(bz0), .i_done(dn0)
  );

  scene_init_engine #(
    .X_W(8), .Y_W(7), .C_W(3), .BOX_X0(10), .BOX_Y0(20), .BOX_W(2), .BOX_H(2),
    .BOX_C(3'b010), .N_SPRITES(1), .SPRITE_TABLE({8'd5, 7'd6, 3'd2})
  ) u_dut1 (
    .clock(clk), .reset(reset), .go(go1), .draw_ready(draw_ready),
    .init_out(init1), .load_init(li1), .draw(dr1), .busy(bz1), .i_done(dn1)
  );

  function automatic logic [17:0] mk(input int x, input int y, input int c);
    return {x[7:0], y[6:0], c[2:0]};
  endfunction

  // Reference point list built directly from the geometry description.
  task automatic build_exp(input int sel);
    int x0, y0, w, h, c;
    exp_q.delete();
    if (sel == 0) begin x0 = 40; y0 = 40; w = 80; h = 40; c = 7; end
    else          begin x0 = 10; y0 = 20; w = 2;  h = 2;  c = 2; end
`ifdef SCENE_INIT_FILL_EN
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++) exp_q.push_back(mk(xx, yy, c));
`else
    for (int i = 0; i < w; i++)       exp_q.push_back(mk(x0 + i, y0, c));
    for (int j = 1; j < h; j++)       exp_q.push_back(mk(x0 + w - 1, y0 + j, c));
    for (int i = w - 2; i >= 0; i--)  exp_q.push_back(mk(x0 + i, y0 + h - 1, c));
    for (int j = h - 2; j >= 1; j--)  exp_q.push_back(mk(x0, y0 + j, c));
`endif
    if (sel == 0) begin
      exp_q.push_back(mk(80, 79, 1));
      exp_q.push_back(mk(60, 79, 4));
      exp_q.push_back(mk(100, 79, 4));
    end else begin
      exp_q.push_back(mk(5, 6, 2));
    end
  endtask

  // Starts a sequence (called just after a falling edge) and records every loaded word.
  task automatic run_seq(input int sel, input bit rnd_rdy, input int hold_at,
                         input bit go_noise, input int stop_loads);
    int nload, hold_left;
    logic li, dr, dn;
    logic [17:0] w;
    got.delete(); hold_draw.delete(); hold_word.delete();
    t_first = -1; t_done = -1; timed_out = 1'b0; nload = 0; hold_left = 0;
    if (sel == 1) go1 = 1'b1; else go0 = 1'b1;
    draw_ready = 1'b1;
    for (int cyc = 1; cyc <= 40000; cyc++) begin
      @(negedge clk);
      li = sel ? li1 : li0;
      dr = sel ? dr1 : dr0;
      dn = sel ? dn1 : dn0;
      w  = sel ? init1 : init0;
      if (sel == 1) go1 = go_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      else          go0 = go_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (li) begin
        nload++;
        got.push_back(w);
        if (t_first < 0) t_first = cyc;
        if (nload == hold_at) hold_left = 6;
      end
      if (hold_left > 0) begin
        if (!li) begin
          hold_draw.push_back(dr);
          hold_word.push_back(w);
        end
        draw_ready = 1'b0;
        hold_left--;
      end else begin
        draw_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (dn) begin
        t_done = cyc;
        break;
      end
      if (stop_loads > 0 && nload >= stop_loads) break;
    end
    go0 = 1'b0; go1 = 1'b0; draw_ready = 1'b1;
    if (t_done < 0 && stop_loads == 0) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (init0 !== 18'd0) begin n_bad++; $display("FAIL reset_init_out got=%h want=0", init0); end
    n_cmp++; if (li0 !== 1'b0) begin n_bad++; $display("FAIL reset_load_init got=%b want=0", li0); end
    n_cmp++; if (dr0 !== 1'b0) begin n_bad++; $display("FAIL reset_draw got=%b want=0", dr0); end
    n_cmp++; if (bz0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bz0); end
    n_cmp++; if (dn0 !== 1'b0) begin n_bad++; $display("FAIL reset_i_done got=%b want=0", dn0); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bz0 !== 1'b0 || li0 !== 1'b0) begin n_bad++; $display("FAIL idle_without_go busy=%b load=%b want=0", bz0, li0); end
  endtask

  task automatic check_words(input string tag);
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL %s_timeout got=no i_done want=i_done", tag); end
    n_cmp++;
    if (got.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL %s_count got=%0d want=%0d", tag, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL %s_word[%0d] got=%h want=%h", tag, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_default_seq;
    build_exp(0);
    run_seq(0, 1'b0, 0, 1'b0, 0);
    check_words("default");
    n_cmp++;
    if (t_done - t_first !== 2 * exp_q.size()) begin
      n_bad++; $display("FAIL default_latency got=%0d want=%0d", t_done - t_first, 2 * exp_q.size());
    end
    if (got.size() >= 1) begin
      n_cmp++; if (got[0] !== mk(40, 40, 7)) begin n_bad++; $display("FAIL first_word got=%h want=%h", got[0], mk(40, 40, 7)); end
    end
`ifndef SCENE_INIT_FILL_EN
    n_cmp++;
    if (t_done - t_first !== 478) begin n_bad++; $display("FAIL latency_478 got=%0d want=478", t_done - t_first); end
    if (got.size() >= 239) begin
      n_cmp++; if (got[79]  !== mk(119, 40, 7)) begin n_bad++; $display("FAIL top_right got=%h want=%h", got[79], mk(119, 40, 7)); end
      n_cmp++; if (got[197] !== mk(40, 79, 7))  begin n_bad++; $display("FAIL bottom_left got=%h want=%h", got[197], mk(40, 79, 7)); end
      n_cmp++; if (got[235] !== mk(40, 41, 7))  begin n_bad++; $display("FAIL last_border got=%h want=%h", got[235], mk(40, 41, 7)); end
      n_cmp++; if (got[236] !== mk(80, 79, 1))  begin n_bad++; $display("FAIL sprite0 got=%h want=%h", got[236], mk(80, 79, 1)); end
      n_cmp++; if (got[238] !== mk(100, 79, 4)) begin n_bad++; $display("FAIL sprite2 got=%h want=%h", got[238], mk(100, 79, 4)); end
    end
`else
    n_cmp++;
    if (t_done - t_first !== 6406) begin n_bad++; $display("FAIL latency_6406 got=%0d want=6406", t_done - t_first); end
`endif
  endtask

  task automatic test_backpressure;
    build_exp(0);
    run_seq(0, 1'b0, 3, 1'b0, 0);
    check_words("bp");
    n_cmp++;
    if (t_done - t_first !== 2 * exp_q.size() + 5) begin
      n_bad++; $display("FAIL bp_latency got=%0d want=%0d", t_done - t_first, 2 * exp_q.size() + 5);
    end
    n_cmp++;
    if (hold_draw.size() !== 5) begin n_bad++; $display("FAIL bp_hold_len got=%0d want=5", hold_draw.size()); end
    for (int i = 0; i < hold_draw.size(); i++) begin
      n_cmp++;
      if (hold_draw[i] !== 1'b1 || hold_word[i] !== mk(42, 40, 7)) begin
        n_bad++; $display("FAIL bp_hold[%0d] got=draw %b word %h want=draw 1 word %h", i, hold_draw[i], hold_word[i], mk(42, 40, 7));
      end
    end
  endtask

  task automatic test_reset_mid;
    run_seq(0, 1'b0, 0, 1'b0, 85);
    n_cmp++; if (bz0 !== 1'b1) begin n_bad++; $display("FAIL mid_busy got=%b want=1", bz0); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({init0, li0, dr0, bz0, dn0} !== 22'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs got=%h/%b%b%b%b want=0", init0, li0, dr0, bz0, dn0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (bz0 !== 1'b0 || li0 !== 1'b0) begin n_bad++; $display("FAIL mid_no_resume busy=%b load=%b want=0", bz0, li0); end
    build_exp(0);
    run_seq(0, 1'b1, 0, 1'b0, 0);
    check_words("after_reset");
  endtask

  task automatic test_go_noise;
    build_exp(0);
    run_seq(0, 1'b1, 0, 1'b1, 0);
    check_words("go_noise");
    go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    n_cmp++; if (dn0 !== 1'b0) begin n_bad++; $display("FAIL restart_done got=%b want=0", dn0); end
    n_cmp++; if (li0 !== 1'b1) begin n_bad++; $display("FAIL restart_load got=%b want=1", li0); end
    n_cmp++; if (init0 !== mk(40, 40, 7)) begin n_bad++; $display("FAIL restart_word got=%h want=%h", init0, mk(40, 40, 7)); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_small_box;
    build_exp(1);
    run_seq(1, 1'b1, 0, 1'b0, 0);
    check_words("small_rand");
    run_seq(1, 1'b0, 0, 1'b0, 0);
    check_words("small");
    n_cmp++;
    if (t_done - t_first !== 10) begin n_bad++; $display("FAIL small_latency got=%0d want=10", t_done - t_first); end
  endtask

  initial begin
    reset = 1'b1; go0 = 1'b0; go1 = 1'b0; draw_ready = 1'b1;
    test_reset;
    test_default_seq;
    test_backpressure;
    test_reset_mid;
    test_go_noise;
    test_small_box;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
